// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encodings, result flag positions and the
// iteration-counter width helper used by the multi-cycle multiplier and divider.
package alu_pkg;

  localparam logic [1:0] StateIdle = 2'd0;
  localparam logic [1:0] StateCalc = 2'd1;
  localparam logic [1:0] StateFix  = 2'd2;

  typedef enum logic [1:0] {
    StIdle = StateIdle,
    StCalc = StateCalc,
    StFix  = StateFix
  } alu_state_e;

  localparam int unsigned FlagDivZero  = 0;
  localparam int unsigned FlagOverflow = 1;
  localparam int unsigned NumFlags     = 2;

  // Enough bits to count 0..w iterations.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/abs_n_bit.sv
// Combinational conditional two's-complement negate: yields |value| when negate is the
// operand's sign bit, or applies a result sign fix-up when negate is a sign mismatch.
module abs_n_bit #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] mag
);

  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
  always_comb begin
    mag = value;
    if (negate) begin
      mag = (~value) + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/divider_n_bit_signed.sv
// Sequential signed restoring divider: n quotient bits, one per cycle, then a sign-fix cycle.
// Optional build macro DIV_FAST_ZERO_EN skips the iteration phase for a zero divisor.
module divider_n_bit_signed
  import alu_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         valid,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         div_zero,
  output logic         overflow
);

  localparam int unsigned CntW = cnt_width(n);
  localparam logic [CntW-1:0] CntLast = CntW'(n - 1);
  localparam logic [n-1:0] MinVal = {1'b1, {(n-1){1'b0}}};

  alu_state_e          state_q;
  logic [n:0]          rem_q;
  logic [n-1:0]        dq_q;
  logic [n-1:0]        dvs_q;
  logic [n-1:0]        dvd_q;
  logic                sa_q;
  logic                sb_q;
  logic [CntW-1:0]     cnt_q;
  logic [NumFlags-1:0] flags_q;

  logic [n-1:0] dvd_mag;
  logic [n-1:0] dvs_mag;
  logic [n-1:0] q_signed;
  logic [n-1:0] r_signed;
  logic [n+1:0] shifted;
  logic [n+1:0] diff;
  logic         trial_ok;
  logic [NumFlags-1:0] flags_in;

  abs_n_bit #(.W(n)) u_abs_dvd (
    .value  (dividend),
    .negate (dividend[n-1]),
    .mag    (dvd_mag)
  );

  abs_n_bit #(.W(n)) u_abs_dvs (
    .value  (divisor),
    .negate (divisor[n-1]),
    .mag    (dvs_mag)
  );

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  abs_n_bit #(.W(n)) u_fix_quo (
    .value  (dq_q),
    .negate (sa_q ^ sb_q),
    .mag    (q_signed)
  );

  abs_n_bit #(.W(n)) u_fix_rem (
    .value  (rem_q[n-1:0]),
    .negate (sa_q),
    .mag    (r_signed)
  );

  always_comb begin
    shifted  = {rem_q, dq_q[n-1]};
    diff     = shifted - {2'b00, dvs_q};
    trial_ok = ~diff[n+1];
    flags_in = '0;
    flags_in[FlagDivZero]  = (divisor == '0);
    flags_in[FlagOverflow] = (dividend == MinVal) && (divisor == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      cnt_q     <= '0;
      flags_q   <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q   <= dividend;
            sa_q    <= dividend[n-1];
            sb_q    <= divisor[n-1];
            dq_q    <= dvd_mag;
            dvs_q   <= dvs_mag;
            rem_q   <= '0;
            cnt_q   <= '0;
            flags_q <= flags_in;
            busy    <= 1'b1;
`ifdef DIV_FAST_ZERO_EN
            state_q <= flags_in[FlagDivZero] ? StFix : StCalc;
`else
            state_q <= StCalc;
`endif
          end
        end
        StCalc: begin
          rem_q <= trial_ok ? diff[n:0] : shifted[n:0];
          dq_q  <= {dq_q[n-2:0], trial_ok};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          // MIN / -1 needs no override: the magnitude 2^(n-1) wraps back to MIN.
          quotient  <= flags_q[FlagDivZero] ? '1 : q_signed;
          remainder <= flags_q[FlagDivZero] ? dvd_q : r_signed;
          div_zero  <= flags_q[FlagDivZero];
          overflow  <= flags_q[FlagOverflow];
          valid     <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
